dc_sequencer: RTL and testbench

Control FSM for the digital-controller PID datapath: it drives the datapath select and enable strobes to compute err, sumerr, diferr and preverr. It then fetches the P, I and D coefficients from EEPROM, runs three 14-iteration Booth multiplies and accumulates the products into duty. It sits directly upstream of the datapath, produces every c_* control, and consumes the datapath's c_prod (prod[1:0]) feedback.

---
 rtl/dc_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_dc_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dc_sequencer.sv
// Control sequencer for the PID datapath: error terms, coefficient fetch,
// three Booth multiplies and product accumulation into duty.
module dc_sequencer #(
  parameter int EEP_LAT    = 2,
  parameter int MULT_ITERS = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       wrt_xset,
  input  logic [1:0] c_prod,
  output logic [2:0] c_asel,
  output logic [2:0] c_bsel,
  output logic       c_err,
  output logic       c_duty,
  output logic       c_sumerr,
  output logic       c_diferr,
  output logic       c_xset,
  output logic       c_preverr,
  output logic       c_pid,
  output logic       c_init_prod,
  output logic       c_subtract,
  output logic       c_multsat,
  output logic       c_clr_duty,
  output logic       c_eep_reg,
  output logic       eep_rd,
  output logic [1:0] eep_addr,
  output logic       busy,
  output logic       done
);

  localparam int CNT_MAX = (MULT_ITERS > EEP_LAT) ? MULT_ITERS : EEP_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_ITERS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((EEP_LAT > 1) ? EEP_LAT - 2 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_XSET, S_ERR, S_SUM, S_DIF, S_PREV,
    S_RD, S_WAIT, S_LOAD, S_INIT, S_MULT, S_ACC, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       term, term_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      term  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      term  <= term_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    term_nxt  = term;
    case (state)
      S_IDLE: begin
        // go wins over a simultaneous wrt_xset, which is simply dropped
        if (go)            state_nxt = S_ERR;
        else if (wrt_xset) state_nxt = S_XSET;
      end
      S_XSET: state_nxt = S_IDLE;
      S_ERR:  state_nxt = S_SUM;
      S_SUM:  state_nxt = S_DIF;
      S_DIF:  state_nxt = S_PREV;
      S_PREV: begin
        term_nxt  = 2'd0;
        state_nxt = S_RD;
      end
      S_RD: begin
        cnt_nxt   = '0;
        state_nxt = (EEP_LAT == 1) ? S_LOAD : S_WAIT;
      end
      S_WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == WAIT_LAST) state_nxt = S_LOAD;
      end
      S_LOAD: state_nxt = S_INIT;
      S_INIT: begin
        cnt_nxt   = '0;
        state_nxt = S_MULT;
      end
      S_MULT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == MULT_LAST) state_nxt = S_ACC;
      end
      S_ACC: begin
        if (term == 2'd2) begin
          state_nxt = S_DONE;
        end else begin
          term_nxt  = term + 2'd1;
          state_nxt = S_RD;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    c_asel      = 3'd7;
    c_bsel      = 3'd3;
    c_err       = 1'b0;
    c_duty      = 1'b0;
    c_sumerr    = 1'b0;
    c_diferr    = 1'b0;
    c_xset      = 1'b0;
    c_preverr   = 1'b0;
    c_pid       = 1'b0;
    c_init_prod = 1'b0;
    c_subtract  = 1'b0;
    c_multsat   = 1'b0;
    c_clr_duty  = 1'b0;
    c_eep_reg   = 1'b0;
    eep_rd      = 1'b0;
    eep_addr    = 2'd0;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    case (state)
      S_XSET: begin
        c_asel = 3'd0;
        c_xset = 1'b1;
      end
      S_ERR: begin
        c_asel     = 3'd1;
        c_bsel     = 3'd0;
        c_subtract = 1'b1;
        c_err      = 1'b1;
        c_clr_duty = 1'b1;
      end
      S_SUM: begin
        c_asel   = 3'd2;
        c_bsel   = 3'd1;
        c_sumerr = 1'b1;
      end
      S_DIF: begin
        c_asel     = 3'd2;
        c_bsel     = 3'd2;
        c_subtract = 1'b1;
        c_diferr   = 1'b1;
      end
      S_PREV: begin
        c_asel    = 3'd2;
        c_preverr = 1'b1;
      end
      S_RD: begin
        eep_rd   = 1'b1;
        eep_addr = term;
      end
      S_WAIT: eep_addr = term;
      S_LOAD: begin
        eep_addr  = term;
        c_eep_reg = 1'b1;
        c_pid     = 1'b1;
      end
      S_INIT: begin
        // multiplicand is err, sumerr or diferr for P, I, D respectively
        case (term)
          2'd0:    c_asel = 3'd2;
          2'd1:    c_asel = 3'd5;
          default: c_asel = 3'd6;
        endcase
        c_init_prod = 1'b1;
      end
      S_MULT: begin
        c_asel = 3'd3;
        case (c_prod)
          2'b01: c_bsel = 3'd4;
          2'b10: begin
            c_bsel     = 3'd4;
            c_subtract = 1'b1;
          end
          default: c_bsel = 3'd3;
        endcase
      end
      S_ACC: begin
        c_asel    = 3'd4;
        c_bsel    = 3'd6;
        c_multsat = 1'b1;
        c_duty    = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dc_sequencer.sv
// Bench for dc_sequencer: every cycle of an update is compared against a
// cycle-index model of the control schedule.
module tb_dc_sequencer;

  localparam int TB_LAT   = 2;
  localparam int TB_ITERS = 14;
  localparam int TERM_CYC = TB_LAT + 3 + TB_ITERS;
  localparam int DONE_CYC = 5 + 3 * TERM_CYC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go, wrt_xset;
  logic [1:0] c_prod;
  logic [2:0] c_asel, c_bsel;
  logic       c_err, c_duty, c_sumerr, c_diferr, c_xset, c_preverr, c_pid;
  logic       c_init_prod, c_subtract, c_multsat, c_clr_duty, c_eep_reg;
  logic       eep_rd, busy, done;
  logic [1:0] eep_addr;
  logic [22:0] obs;

  int checks = 0;
  int errors = 0;

  dc_sequencer #(.EEP_LAT(TB_LAT), .MULT_ITERS(TB_ITERS)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .wrt_xset(wrt_xset), .c_prod(c_prod),
    .c_asel(c_asel), .c_bsel(c_bsel), .c_err(c_err), .c_duty(c_duty),
    .c_sumerr(c_sumerr), .c_diferr(c_diferr), .c_xset(c_xset),
    .c_preverr(c_preverr), .c_pid(c_pid), .c_init_prod(c_init_prod),
    .c_subtract(c_subtract), .c_multsat(c_multsat), .c_clr_duty(c_clr_duty),
    .c_eep_reg(c_eep_reg), .eep_rd(eep_rd), .eep_addr(eep_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign obs = {c_asel, c_bsel, c_err, c_duty, c_sumerr, c_diferr, c_xset,
                c_preverr, c_pid, c_init_prod, c_subtract, c_multsat,
                c_clr_duty, c_eep_reg, eep_rd, eep_addr, busy, done};

  // Expected outputs in cycle n of an update whose go was taken at edge 0.
  function automatic logic [22:0] model(input int n, input logic [1:0] cp);
    logic [2:0] a, b;
    logic err, duty, sum, dif, prev, pid, initp, sub, msat, clr, ereg, rd, bsy, dn;
    logic [1:0] addr;
    int k, o;
    a = 3'd7; b = 3'd3; addr = 2'd0;
    {err, duty, sum, dif, prev, pid, initp, sub, msat, clr, ereg, rd, bsy, dn} = '0;
    bsy = (n >= 1 && n <= DONE_CYC);
    if (n == 1) begin a = 3'd1; b = 3'd0; sub = 1'b1; err = 1'b1; clr = 1'b1; end
    else if (n == 2) begin a = 3'd2; b = 3'd1; sum = 1'b1; end
    else if (n == 3) begin a = 3'd2; b = 3'd2; sub = 1'b1; dif = 1'b1; end
    else if (n == 4) begin a = 3'd2; prev = 1'b1; end
    else if (n == DONE_CYC) dn = 1'b1;
    else if (n >= 5 && n < DONE_CYC) begin
      k = (n - 5) / TERM_CYC;
      o = (n - 5) % TERM_CYC;
      if (o <= TB_LAT) addr = 2'(k);
      if (o == 0) rd = 1'b1;
      if (o == TB_LAT) begin ereg = 1'b1; pid = 1'b1; end
      if (o == TB_LAT + 1) begin
        a = (k == 0) ? 3'd2 : (k == 1) ? 3'd5 : 3'd6;
        initp = 1'b1;
      end
      if (o >= TB_LAT + 2 && o < TB_LAT + 2 + TB_ITERS) begin
        a = 3'd3;
        if (cp == 2'b01) b = 3'd4;
        if (cp == 2'b10) begin b = 3'd4; sub = 1'b1; end
      end
      if (o == TERM_CYC - 1) begin a = 3'd4; b = 3'd6; msat = 1'b1; duty = 1'b1; end
    end
    return {a, b, err, duty, sum, dif, 1'b0, prev, pid, initp, sub, msat, clr,
            ereg, rd, addr, bsy, dn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // mode 0: random c_prod, 1: held 00, 2: repeating 01,10,11,00 from MULT iteration 0
  task automatic run_op(input int mode, input bit both, input int stop, input string nm);
    logic [1:0] pat [4];
    logic [1:0] cp;
    int last, n_pid, n_init, n_duty, n_rd, n_done, n_busy;
    pat = '{2'b01, 2'b10, 2'b11, 2'b00};
    last = (stop > 0) ? stop : DONE_CYC + 1;
    {n_pid, n_init, n_duty, n_rd, n_done, n_busy} = '0;
    @(negedge clk);
    go = 1'b1; wrt_xset = both; c_prod = 2'b00;
    #1 chk($sformatf("%s_start", nm), 32'(obs), 32'(model(0, 2'b00)));
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      case (mode)
        0:       cp = 2'($urandom_range(0, 3));
        1:       cp = 2'b00;
        default: cp = pat[(n + 400 - TB_LAT - 7) % 4];
      endcase
      c_prod = cp;
      if (n <= DONE_CYC) begin
        go       = 1'($urandom_range(0, 1));
        wrt_xset = 1'($urandom_range(0, 1));
      end else begin
        go = 1'b0; wrt_xset = 1'b0;
      end
      #1 chk($sformatf("%s_cyc%0d", nm, n), 32'(obs), 32'(model(n, cp)));
      n_pid += int'(c_pid); n_init += int'(c_init_prod); n_duty += int'(c_duty);
      n_rd += int'(eep_rd); n_done += int'(done); n_busy += int'(busy);
    end
    if (stop == 0) begin
      chk({nm, "_n_pid"},  32'(n_pid),  32'd3);
      chk({nm, "_n_init"}, 32'(n_init), 32'd3);
      chk({nm, "_n_duty"}, 32'(n_duty), 32'd3);
      chk({nm, "_n_rd"},   32'(n_rd),   32'd3);
      chk({nm, "_n_done"}, 32'(n_done), 32'd1);
      chk({nm, "_n_busy"}, 32'(n_busy), 32'(DONE_CYC));
    end
  endtask

  task automatic xset_op(input string nm);
    logic [22:0] e;
    e = model(0, 2'b00);
    e[22:20] = 3'd0;
    e[12] = 1'b1;
    e[1] = 1'b1;
    @(negedge clk);
    go = 1'b0; wrt_xset = 1'b1;
    #1 chk({nm, "_idle"}, 32'(obs), 32'(model(0, 2'b00)));
    @(negedge clk);
    wrt_xset = 1'b0;
    #1 chk({nm, "_xset"}, 32'(obs), 32'(e));
    @(negedge clk);
    #1 chk({nm, "_back"}, 32'(obs), 32'(model(0, 2'b00)));
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; wrt_xset = 1'b0; c_prod = 2'b00;
    #2 chk("por", 32'(obs), 32'(model(0, 2'b00)));
    @(negedge clk);
    #1 chk("por_hold", 32'(obs), 32'(model(0, 2'b00)));
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("idle", 32'(obs), 32'(model(0, 2'b00)));

    xset_op("xset1");
    run_op(1, 1'b0, 0, "held00");
    run_op(2, 1'b0, 0, "booth");
    run_op(0, 1'b1, 0, "go_xset");
    xset_op("xset2");

    // asynchronous reset in the middle of the first multiply
    run_op(0, 1'b0, 5 + TB_LAT + 5, "pre_rst");
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 32'(obs), 32'(model(0, 2'b00)));
    go = 1'b0; wrt_xset = 1'b0;
    @(negedge clk);
    #1 chk("rst_held", 32'(obs), 32'(model(0, 2'b00)));
    #1 rst_n = 1'b1;
    #1 chk("rst_rel", 32'(obs), 32'(model(0, 2'b00)));
    @(negedge clk);
    #1 chk("rst_idle", 32'(obs), 32'(model(0, 2'b00)));
    run_op(0, 1'b0, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
